mask_cvt_seq: RTL and testbench

- Sequential masked share-conversion unit for the masking ISE.
- Converts 2-share arithmetic (x = a0 + a1 mod 2^XLEN) to 2-share boolean (x = b0 ^ b1), and the reverse.
- Uses an iterative masked ripple adder over boolean shares, CHUNK bits per cycle, with fresh randomness each cycle.
- Sits beside the ALU as a multi-cycle functional unit; the execute stage drives it through valid/ready handshakes.

---
 rtl/mask_cvt_seq_pkg.sv | 24 ++
 rtl/mask_cvt_seq_if.sv | 29 ++
 rtl/mask_cvt_seq_isw_and.sv | 14 +
 rtl/mask_cvt_seq.sv | 174 +++++++++++++++++
 tb/tb_mask_cvt_seq.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mask_cvt_seq_pkg.sv
// Shared types and helpers for the masked arithmetic/boolean share converter.
// Holds the FSM state enum, mode encodings and chunk-count helpers.
package mask_cvt_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MASK0 = 3'd1,
        MASK1 = 3'd2,
        ADD   = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic MODE_A2B = 1'b0;
    localparam logic MODE_B2A = 1'b1;

    function automatic int calc_n(input int xlen, input int chunk);
        return xlen / chunk;
    endfunction

    function automatic int calc_cnt_w(input int xlen, input int chunk);
        return (calc_n(xlen, chunk) > 1) ? $clog2(calc_n(xlen, chunk)) : 1;
    endfunction

endpackage

// File: rtl/mask_cvt_seq_if.sv
// Request/response bundle between the execute stage (master) and the share converter (slave).
interface mask_cvt_seq_if #(
    parameter int XLEN = 32
);
    // A transfer happens on a rising clock edge where valid && ready are both high;
    // once raised, valid and its payload stay stable until that edge; flush overrides both.
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic            req_mode;
    logic [XLEN-1:0] req_s0;
    logic [XLEN-1:0] req_s1;
    logic [XLEN-1:0] rng;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_s0;
    logic [XLEN-1:0] rsp_s1;

    modport master (
        output flush, req_valid, req_mode, req_s0, req_s1, rng, rsp_ready,
        input  req_ready, rsp_valid, rsp_s0, rsp_s1
    );

    modport slave (
        input  flush, req_valid, req_mode, req_s0, req_s1, rng, rsp_ready,
        output req_ready, rsp_valid, rsp_s0, rsp_s1
    );

endinterface

// File: rtl/mask_cvt_seq_isw_and.sv
// Single-bit two-share ISW AND gadget refreshed by one random bit.
module mask_isw_and (
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    input  logic r,
    output logic c0,
    output logic c1
);
    // The random bit is folded in before the cross terms so no partial sum exposes a secret.
    assign c0 = (a0 & b0) ^ r;
    assign c1 = (a1 & b1) ^ ((r ^ (a0 & b1)) ^ (a1 & b0));
endmodule

// File: rtl/mask_cvt_seq.sv
// Sequential A2B/B2A share converter: masked ripple adder over boolean shares, CHUNK bits/cycle.
// Optional MASK_CVT_ZEROISE_EN clears internal shares on completion/flush and gates idle outputs.
module mask_cvt_seq
    import mask_cvt_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 4
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    mask_cvt_seq_if.slave bus,
    output state_e        dbg_state
);
    localparam int N  = calc_n(XLEN, CHUNK);
    localparam int CW = calc_cnt_w(XLEN, CHUNK);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [XLEN-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [XLEN-1:0] r_q, r_d, s0_q, s0_d, s1_q, s1_d;
    logic            c0_q, c0_d, c1_q, c1_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [CHUNK-1:0] xc0, xc1, yc0, yc1, sum0, sum1;
    logic             cout0, cout1;
    logic [XLEN-1:0]  res0, res1;

    assign xc0 = x0_q[cnt_q*CHUNK +: CHUNK];
    assign xc1 = x1_q[cnt_q*CHUNK +: CHUNK];
    assign yc0 = y0_q[cnt_q*CHUNK +: CHUNK];
    assign yc1 = y1_q[cnt_q*CHUNK +: CHUNK];

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic cin0, cin1, co0, co1, p0, p1, xy0, xy1, cp0, cp1;
        if (i == 0) begin : g_first
            assign cin0 = c0_q;
            assign cin1 = c1_q;
        end else begin : g_next
            assign cin0 = g_bit[i-1].co0;
            assign cin1 = g_bit[i-1].co1;
        end
        assign p0 = xc0[i] ^ yc0[i];
        assign p1 = xc1[i] ^ yc1[i];
        mask_isw_and u_xy (.a0(xc0[i]), .a1(xc1[i]), .b0(yc0[i]), .b1(yc1[i]),
                           .r(bus.rng[2*i]), .c0(xy0), .c1(xy1));
        mask_isw_and u_cp (.a0(cin0), .a1(cin1), .b0(p0), .b1(p1),
                           .r(bus.rng[2*i+1]), .c0(cp0), .c1(cp1));
        assign co0     = xy0 ^ cp0;
        assign co1     = xy1 ^ cp1;
        assign sum0[i] = p0 ^ cin0;
        assign sum1[i] = p1 ^ cin1;
    end
    assign cout0 = g_bit[CHUNK-1].co0;
    assign cout1 = g_bit[CHUNK-1].co1;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        r_d     = r_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    mode_d  = bus.req_mode;
                    x0_d    = bus.req_s0;
                    y0_d    = bus.req_s1;
                    state_d = MASK0;
                end
            end
            MASK0: begin
                // B2A folds b1 into X so the adder's X operand is the full secret b0^b1.
                x0_d    = x0_q ^ bus.rng;
                x1_d    = (mode_q == MODE_B2A) ? (bus.rng ^ y0_q) : bus.rng;
                state_d = MASK1;
            end
            MASK1: begin
                if (mode_q == MODE_B2A) begin
                    r_d  = bus.rng;
                    y0_d = y0_q ^ ((~bus.rng) + XLEN'(1));
                    y1_d = y0_q;
                end else begin
                    y0_d = y0_q ^ bus.rng;
                    y1_d = bus.rng;
                end
                c0_d    = 1'b0;
                c1_d    = 1'b0;
                cnt_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                s0_d[cnt_q*CHUNK +: CHUNK] = sum0;
                s1_d[cnt_q*CHUNK +: CHUNK] = sum1;
                c0_d  = cout0;
                c1_d  = cout1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
`ifdef MASK_CVT_ZEROISE_EN
        if (bus.flush || (state_q == DONE && bus.rsp_ready)) begin
            x0_d  = '0;
            x1_d  = '0;
            y0_d  = '0;
            y1_d  = '0;
            r_d   = '0;
            s0_d  = '0;
            s1_d  = '0;
            c0_d  = 1'b0;
            c1_d  = 1'b0;
            cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            mode_q  <= MODE_A2B;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            r_q     <= '0;
            s0_q    <= '0;
            s1_q    <= '0;
            c0_q    <= 1'b0;
            c1_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            r_q     <= r_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            cnt_q   <= cnt_d;
        end
    end

    // s1 is gated by mode so the two sum shares are only ever recombined for B2A (x - r).
    assign res0 = s0_q ^ (s1_q & {XLEN{mode_q == MODE_B2A}});
    assign res1 = (mode_q == MODE_B2A) ? r_q : s1_q;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign dbg_state     = state_q;
`ifdef MASK_CVT_ZEROISE_EN
    assign bus.rsp_s0 = (state_q == DONE) ? res0 : '0;
    assign bus.rsp_s1 = (state_q == DONE) ? res1 : '0;
`else
    assign bus.rsp_s0 = res0;
    assign bus.rsp_s1 = res1;
`endif

endmodule

// File: tb/tb_mask_cvt_seq.sv
// Self-checking bench for mask_cvt_seq: A2B/B2A invariants, latency, flush, backpressure, reset.
module tb_mask_cvt_seq;
    import mask_cvt_seq_pkg::*;

    localparam int XLEN  = 32;
    localparam int CHUNK = 4;
    localparam int LAT   = XLEN / CHUNK + 2;

    logic   g_clk;
    logic   g_resetn;
    state_e dbg_state;

    mask_cvt_seq_if #(.XLEN(XLEN)) bus ();

    mask_cvt_seq #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    logic [XLEN-1:0] exp_q[$];
    int              n_tests;
    int              n_fail;
    int              rng_sel;
    logic [XLEN-1:0] rng_fix;

    // ---------------- clock / reset ----------------
    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // ---------------- driver tasks ----------------
    task automatic next_rng();
        case (rng_sel)
            0:       bus.rng = '0;
            1:       bus.rng = rng_fix;
            default: bus.rng = $urandom;
        endcase
    endtask

    task automatic drive_req(input logic mode, input logic [XLEN-1:0] s0, input logic [XLEN-1:0] s1);
        bus.req_valid = 1'b1;
        bus.req_mode  = mode;
        bus.req_s0    = s0;
        bus.req_s1    = s1;
        next_rng();
        exp_q.push_back(mode ? (s0 ^ s1) : (s0 + s1));
        @(posedge g_clk); #1;
        bus.req_valid = 1'b0;
        bus.req_mode  = 1'($urandom_range(0, 1));
        bus.req_s0    = $urandom;
        bus.req_s1    = $urandom;
        next_rng();
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 100) begin
            @(posedge g_clk); #1;
            lat++;
            next_rng();
        end
    endtask

    task automatic do_op(input logic mode, input logic [XLEN-1:0] s0, input logic [XLEN-1:0] s1,
                         input int hold, output int lat, output logic [XLEN-1:0] r0,
                         output logic [XLEN-1:0] r1, output bit stable, output bit post_ok);
        drive_req(mode, s0, s1);
        wait_rsp(lat);
        r0     = bus.rsp_s0;
        r1     = bus.rsp_s1;
        stable = 1'b1;
        repeat (hold) begin
            bus.req_valid = 1'b1;
            @(posedge g_clk); #1;
            next_rng();
            if (bus.rsp_s0 !== r0 || bus.rsp_s1 !== r1 || bus.req_ready !== 1'b0 ||
                bus.rsp_valid !== 1'b1) stable = 1'b0;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge g_clk); #1;
        bus.rsp_ready = 1'b0;
        next_rng();
        post_ok = (bus.req_ready === 1'b1) && (bus.rsp_valid === 1'b0) && (dbg_state === IDLE);
`ifdef MASK_CVT_ZEROISE_EN
        post_ok = post_ok && (bus.rsp_s0 === '0) && (bus.rsp_s1 === '0);
`endif
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        g_resetn = 1'b0;
        repeat (3) @(posedge g_clk);
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_tests++;
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_tests++;
        if (bus.rsp_s0 !== '0 || bus.rsp_s1 !== '0) begin
            n_fail++; $display("FAIL reset_rsp_shares: got %h/%h want 0/0", bus.rsp_s0, bus.rsp_s1);
        end
        n_tests++;
        if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
        @(negedge g_clk) g_resetn = 1'b1;
        @(posedge g_clk); #1;
    endtask

    task automatic test_a2b_zero_rng();
        int lat; logic [XLEN-1:0] r0, r1, e; bit st, pk;
        rng_sel = 0;
        do_op(MODE_A2B, 32'h12345678, 32'hEDCBA988, 0, lat, r0, r1, st, pk);
        e = exp_q.pop_front();
        n_tests++;
        if (lat !== LAT) begin n_fail++; $display("FAIL a2b_latency: got %0d want %0d", lat, LAT); end
        n_tests++;
        if ((r0 ^ r1) !== e) begin n_fail++; $display("FAIL a2b_zero_rng: got %h want %h", r0 ^ r1, e); end
        n_tests++;
        if (!pk) begin n_fail++; $display("FAIL a2b_return_idle: got 0 want 1"); end
    endtask

    task automatic test_a2b_random();
        int lat; logic [XLEN-1:0] r0, r1, e, a, b; bit st, pk, all_ok;
        rng_sel = 2;
        do_op(MODE_A2B, 32'hFFFFFFFF, 32'h00000001, 0, lat, r0, r1, st, pk);
        e = exp_q.pop_front();
        n_tests++;
        if ((r0 ^ r1) !== e) begin n_fail++; $display("FAIL a2b_wrap: got %h want %h", r0 ^ r1, e); end
        all_ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            do_op(MODE_A2B, a, b, 0, lat, r0, r1, st, pk);
            e = exp_q.pop_front();
            if (lat != LAT || !pk) all_ok = 1'b0;
            n_tests++;
            if ((r0 ^ r1) !== e) begin
                n_fail++; $display("FAIL a2b_rand[%0d]: got %h want %h (in %h %h)", i, r0 ^ r1, e, a, b);
            end
        end
        n_tests++;
        if (!all_ok) begin n_fail++; $display("FAIL a2b_rand_timing: got 0 want 1"); end
    endtask

    task automatic test_b2a();
        int lat; logic [XLEN-1:0] r0, r1, e, a, b; bit st, pk;
        rng_sel = 1;
        rng_fix = 32'h11111111;
        do_op(MODE_B2A, 32'hA5A5A5A5, 32'h0F0F0F0F, 0, lat, r0, r1, st, pk);
        e = exp_q.pop_front();
        n_tests++;
        if (r1 !== 32'h11111111) begin n_fail++; $display("FAIL b2a_r_share: got %h want 11111111", r1); end
        n_tests++;
        if ((r0 + r1) !== e) begin n_fail++; $display("FAIL b2a_fixed: got %h want %h", r0 + r1, e); end
        n_tests++;
        if (lat !== LAT) begin n_fail++; $display("FAIL b2a_latency: got %0d want %0d", lat, LAT); end
        rng_sel = 0;
        do_op(MODE_B2A, 32'hFFFFFFFF, 32'h00000000, 0, lat, r0, r1, st, pk);
        e = exp_q.pop_front();
        n_tests++;
        if ((r0 + r1) !== e) begin n_fail++; $display("FAIL b2a_zero_rng: got %h want %h", r0 + r1, e); end
        rng_sel = 2;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            do_op(MODE_B2A, a, b, 0, lat, r0, r1, st, pk);
            e = exp_q.pop_front();
            n_tests++;
            if ((r0 + r1) !== e || !pk) begin
                n_fail++; $display("FAIL b2a_rand[%0d]: got %h want %h (in %h %h)", i, r0 + r1, e, a, b);
            end
        end
    endtask

    task automatic test_flush();
        int lat; logic [XLEN-1:0] r0, r1, e; bit st, pk, quiet;
        rng_sel = 2;
        drive_req(MODE_A2B, $urandom, $urandom);
        void'(exp_q.pop_back());
        repeat (4) begin @(posedge g_clk); #1; next_rng(); end
        n_tests++;
        if (dbg_state !== ADD) begin n_fail++; $display("FAIL flush_pre_state: got %0d want %0d", dbg_state, ADD); end
        bus.flush = 1'b1;
        @(posedge g_clk); #1;
        bus.flush = 1'b0;
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_add: got ready=%b valid=%b want 1/0", bus.req_ready, bus.rsp_valid);
        end
        quiet = 1'b1;
        repeat (12) begin @(posedge g_clk); #1; if (bus.rsp_valid !== 1'b0) quiet = 1'b0; end
        n_tests++;
        if (!quiet) begin n_fail++; $display("FAIL flush_quiet: got 0 want 1"); end
        do_op(MODE_A2B, 32'h1, 32'h2, 0, lat, r0, r1, st, pk);
        e = exp_q.pop_front();
        n_tests++;
        if ((r0 ^ r1) !== e) begin n_fail++; $display("FAIL flush_recover: got %h want %h", r0 ^ r1, e); end
        // flush beats a same-cycle accept
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        @(posedge g_clk); #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        n_tests++;
        if (dbg_state !== IDLE) begin n_fail++; $display("FAIL flush_accept: got %0d want %0d", dbg_state, IDLE); end
        // flush beats rsp_ready in DONE
        drive_req(MODE_B2A, $urandom, $urandom);
        void'(exp_q.pop_back());
        wait_rsp(lat);
        bus.flush     = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge g_clk); #1;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++; $display("FAIL flush_done: got valid=%b state=%0d want 0/%0d", bus.rsp_valid, dbg_state, IDLE);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [XLEN-1:0] r0, r1, e; bit st, pk;
        rng_sel = 2;
        do_op(MODE_A2B, $urandom, $urandom, 5, lat, r0, r1, st, pk);
        e = exp_q.pop_front();
        n_tests++;
        if (!st) begin n_fail++; $display("FAIL hold_stable: got 0 want 1"); end
        n_tests++;
        if ((r0 ^ r1) !== e) begin n_fail++; $display("FAIL hold_result: got %h want %h", r0 ^ r1, e); end
        n_tests++;
        if (!pk) begin n_fail++; $display("FAIL hold_release: got 0 want 1"); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [XLEN-1:0] r0, r1, e; bit st, pk;
        rng_sel = 2;
        drive_req(MODE_A2B, $urandom, $urandom);
        void'(exp_q.pop_back());
        @(posedge g_clk); #1;
        n_tests++;
        if (dbg_state !== MASK1) begin n_fail++; $display("FAIL rst_pre_state: got %0d want %0d", dbg_state, MASK1); end
        g_resetn = 1'b0;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_s0 !== '0 ||
            bus.rsp_s1 !== '0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL rst_mid: got ready=%b valid=%b s0=%h s1=%h state=%0d want 1/0/0/0/%0d",
                     bus.req_ready, bus.rsp_valid, bus.rsp_s0, bus.rsp_s1, dbg_state, IDLE);
        end
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
        do_op(MODE_B2A, $urandom, $urandom, 0, lat, r0, r1, st, pk);
        e = exp_q.pop_front();
        n_tests++;
        if ((r0 + r1) !== e || lat !== LAT) begin
            n_fail++; $display("FAIL rst_recover: got %h lat %0d want %h lat %0d", r0 + r1, lat, e, LAT);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rng_sel       = 0;
        rng_fix       = '0;
        g_resetn      = 1'b0;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_mode  = 1'b0;
        bus.req_s0    = '0;
        bus.req_s1    = '0;
        bus.rng       = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_a2b_zero_rng();
        test_a2b_random();
        test_b2a();
        test_flush();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
